// File: rtl/load_store_sched_if.sv
// Bundles the request, drain, grant and monitor signals of load_store_sched.
// The master drives requests, drains and the monitor select. The slave (the scheduler) drives grant and status.
interface load_store_sched_if #(
    parameter int CBITS = 15
);
    logic [3:0]       req;
    logic [3:0]       drain;
    logic [1:0]       mon_sel;
    logic [3:0]       grant;
    logic             busy;
    logic [3:0]       full;
    logic [3:0]       empty;
    logic             done;
    logic [CBITS-1:0] mon_level;

    modport master (
        output req, drain, mon_sel,
        input  grant, busy, full, empty, done, mon_level
    );

    modport slave (
        input  req, drain, mon_sel,
        output grant, busy, full, empty, done, mon_level
    );
endinterface

// File: rtl/load_store_sched.sv
// Round-robin scheduler that fills four tanks over one shared load path, with drains and a level monitor.
// Optional feature: define LSS_QUANTUM_EN to limit each grant to QUANTUM consecutive LOAD cycles.
module load_store_sched #(
    parameter int CAP     = 22500,
    parameter int CBITS   = 15,
    parameter int QUANTUM = 64
) (
    input logic              clk,
    input logic              rst,
    load_store_sched_if.slave bus
);
    if (CAP < 1 || CAP >= (1 << CBITS) || QUANTUM < 1) begin : g_bad_cfg
        $error("load_store_sched: CAP must fit in CBITS bits and QUANTUM must be positive");
    end

    localparam logic [CBITS-1:0] CAP_L = CBITS'(CAP);

    typedef enum logic {IDLE, LOAD} state_t;

    state_t           state;
    logic [CBITS-1:0] level [4];
    logic [3:0]       grant;
    logic             busy;
    logic             done;
    logic [1:0]       gidx;
    logic [1:0]       last_grant;

    logic [3:0]       full_w;
    logic [3:0]       empty_w;
    logic [3:0]       elig;
    logic             pick_valid;
    logic [1:0]       pick;
    logic [1:0]       cand;
    logic [CBITS-1:0] gnext;
    logic             reach;

`ifdef LSS_QUANTUM_EN
    localparam int QW = $clog2(QUANTUM + 1);
    logic [QW-1:0] qcnt;
`endif

    always_comb begin
        full_w  = '0;
        empty_w = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            full_w[i]  = (level[i] == CAP_L);
            empty_w[i] = (level[i] == '0);
        end
    end

    assign elig = bus.req & ~full_w;

    // Scan starts one past the last winner; k=4 wraps back onto last_grant itself.
    always_comb begin
        pick_valid = 1'b0;
        pick       = '0;
        cand       = '0;
        for (int unsigned k = 1; k <= 4; k++) begin
            cand = last_grant + 2'(k);
            if (!pick_valid && elig[cand]) begin
                pick_valid = 1'b1;
                pick       = cand;
            end
        end
    end

    always_comb begin
        gnext = bus.drain[gidx] ? level[gidx] : level[gidx] + CBITS'(1);
        reach = (gnext == CAP_L);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            grant      <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            gidx       <= '0;
            last_grant <= 2'd3;
            for (int unsigned i = 0; i < 4; i++) level[i] <= '0;
`ifdef LSS_QUANTUM_EN
            qcnt       <= '0;
`endif
        end else begin
            done <= 1'b0;
            // Saturating drain for every tank; the granted tank is overridden below while it loads.
            for (int unsigned i = 0; i < 4; i++) begin
                if (bus.drain[i] && level[i] != '0) level[i] <= level[i] - CBITS'(1);
            end
            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        grant      <= 4'b0001 << pick;
                        gidx       <= pick;
                        last_grant <= pick;
                        busy       <= 1'b1;
                        state      <= LOAD;
`ifdef LSS_QUANTUM_EN
                        qcnt       <= '0;
`endif
                    end
                end
                LOAD: begin
                    if (!bus.req[gidx]) begin
                        grant <= '0;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        level[gidx] <= gnext;
                        if (reach) begin
                            grant <= '0;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= IDLE;
                        end
`ifdef LSS_QUANTUM_EN
                        else if (qcnt == QW'(QUANTUM - 1)) begin
                            grant <= '0;
                            busy  <= 1'b0;
                            state <= IDLE;
                        end else begin
                            qcnt <= qcnt + QW'(1);
                        end
`endif
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.grant     = grant;
    assign bus.busy      = busy;
    assign bus.done      = done;
    assign bus.full      = full_w;
    assign bus.empty     = empty_w;
    assign bus.mon_level = level[bus.mon_sel];
endmodule
